// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard/forwarding unit: forward-select codes,
// divider sequencer state encoding and the forward-select priority helper.
package hazard_pkg;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  // DIV_CYCLES is limited to 255, so an 8-bit down-counter always suffices
  localparam int DIV_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } div_state_e;

  function automatic logic [1:0] fwd_sel(input logic hit_m, input logic hit_w);
    logic [1:0] sel;
    if (hit_m) begin
      sel = FWD_M;
    end else if (hit_w) begin
      sel = FWD_W;
    end else begin
      sel = FWD_RF;
    end
    return sel;
  endfunction

endpackage

// File: rtl/div_seq.sv
// Multi-cycle divider sequencer: IDLE/BUSY/DONE FSM with a latency
// counter that freezes while the data memory is stalling.
module div_seq
  import hazard_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic div_startE,
  input  logic exc_flush,
  input  logic memstall,
  output logic div_busy,
  output logic div_done,
  output logic divstall
);

  localparam logic [DIV_CNT_W-1:0] CNT_INIT = DIV_CNT_W'(DIV_CYCLES - 1);
  localparam logic [DIV_CNT_W-1:0] CNT_ZERO = {DIV_CNT_W{1'b0}};

  div_state_e           state_q, state_d;
  logic [DIV_CNT_W-1:0] cnt_q, cnt_d;

  // State and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= CNT_ZERO;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; an exception aborts the divide from any state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (exc_flush) begin
      state_d = IDLE;
      cnt_d   = CNT_ZERO;
    end else begin
      case (state_q)
        IDLE: begin
          if (div_startE) begin
            state_d = BUSY;
            cnt_d   = CNT_INIT;
          end else begin
            state_d = IDLE;
          end
        end
        BUSY: begin
          if (memstall) begin
            state_d = BUSY;
          end else if (cnt_q == CNT_ZERO) begin
            state_d = DONE;
          end else begin
            cnt_d = cnt_q - DIV_CNT_W'(1);
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = CNT_ZERO;
        end
      endcase
    end
  end

  // Outputs decoded from state; DONE releases the stall so E advances
  always_comb begin
    div_busy = (state_q != IDLE);
    div_done = (state_q == DONE) & ~exc_flush;
    divstall = ((state_q == IDLE) & div_startE) | (state_q == BUSY);
  end

endmodule

// File: rtl/hazard_unit_mc.sv
// Hazard/forwarding unit for the 5-stage pipeline with divider, memory-wait
// and exception handling. Define HAZARD_PERF_CNT_EN to add stall counters.
module hazard_unit_mc
  import hazard_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter int DIV_CYCLES = 32
`ifdef HAZARD_PERF_CNT_EN
  ,
  parameter int CNT_W      = 32
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] rsD,
  input  logic [REG_AW-1:0] rtD,
  input  logic [REG_AW-1:0] rsE,
  input  logic [REG_AW-1:0] rtE,
  input  logic              use_rsD,
  input  logic              use_rtD,
  input  logic [REG_AW-1:0] write_regE,
  input  logic [REG_AW-1:0] write_regM,
  input  logic [REG_AW-1:0] write_regW,
  input  logic              reg_write_enE,
  input  logic              reg_write_enM,
  input  logic              reg_write_enW,
  input  logic              mem_to_regE,
  input  logic              mem_to_regM,
  input  logic              branchD,
  input  logic              hilo_readE,
  input  logic              hilo_write_enM,
  input  logic              hilo_write_enW,
  input  logic              div_startE,
  input  logic              mem_reqM,
  input  logic              mem_okM,
  input  logic              exc_flush,
  output logic [1:0]        forwardAE,
  output logic [1:0]        forwardBE,
  output logic              forwardAD,
  output logic              forwardBD,
  output logic [1:0]        forward_hilo,
  output logic              stallF,
  output logic              stallD,
  output logic              stallE,
  output logic              stallM,
  output logic              stallW,
  output logic              flushD,
  output logic              flushE,
  output logic              flushM,
  output logic              flushW,
  output logic              div_busy,
  output logic              div_done
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  perf_lw_stall,
  output logic [CNT_W-1:0]  perf_br_stall,
  output logic [CNT_W-1:0]  perf_div_stall,
  output logic [CNT_W-1:0]  perf_mem_stall
`endif
);

  localparam logic [REG_AW-1:0] R0 = {REG_AW{1'b0}};

  logic lwstall, branchstall, memstall, divstall;
  logic hold_all, hold_front;

  div_seq #(.DIV_CYCLES(DIV_CYCLES)) u_div_seq (
    .clk        (clk),
    .rst        (rst),
    .div_startE (div_startE),
    .exc_flush  (exc_flush),
    .memstall   (memstall),
    .div_busy   (div_busy),
    .div_done   (div_done),
    .divstall   (divstall)
  );

  // Data forwarding selects for E and D, plus HI/LO forwarding
  always_comb begin
    forwardAE = fwd_sel((rsE != R0) & (rsE == write_regM) & reg_write_enM,
                        (rsE != R0) & (rsE == write_regW) & reg_write_enW);
    forwardBE = fwd_sel((rtE != R0) & (rtE == write_regM) & reg_write_enM,
                        (rtE != R0) & (rtE == write_regW) & reg_write_enW);
    forwardAD = (rsD != R0) & (rsD == write_regM) & reg_write_enM;
    forwardBD = (rtD != R0) & (rtD == write_regM) & reg_write_enM;
    forward_hilo = fwd_sel(hilo_readE & hilo_write_enM, hilo_readE & hilo_write_enW);
  end

  // Raw hazard conditions before prioritisation
  always_comb begin
    lwstall = mem_to_regE & (write_regE != R0) &
              ((use_rsD & (rsD == write_regE)) | (use_rtD & (rtD == write_regE)));
    branchstall = branchD &
                  ((reg_write_enE & (write_regE != R0) &
                    ((write_regE == rsD) | (write_regE == rtD))) |
                   (mem_to_regM & (write_regM != R0) &
                    ((write_regM == rsD) | (write_regM == rtD))));
    memstall = mem_reqM & ~mem_okM;
  end

  // Priority resolution: flush beats full-pipe stall beats front-end stall
  always_comb begin
    hold_all   = 1'b0;
    hold_front = 1'b0;
    {stallF, stallD, stallE, stallM, stallW} = 5'b00000;
    {flushD, flushE, flushM, flushW}         = 4'b0000;
    if (exc_flush) begin
      {flushD, flushE, flushM, flushW} = 4'b1111;
    end else if (memstall | divstall) begin
      hold_all = 1'b1;
      {stallF, stallD, stallE, stallM, stallW} = 5'b11111;
    end else if (lwstall | branchstall) begin
      hold_front = 1'b1;
      stallF     = 1'b1;
      stallD     = 1'b1;
      flushE     = 1'b1;
    end else begin
      hold_all   = 1'b0;
      hold_front = 1'b0;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [3:0]       win;
  logic [CNT_W-1:0] perf_q [4];
  logic [CNT_W-1:0] perf_d [4];

  // Saturating counters, one per winning stall class (lw, br, div, mem)
  always_comb begin
    win = {hold_all & memstall, hold_all & divstall,
           hold_front & branchstall, hold_front & lwstall};
    for (int i = 0; i < 4; i++) begin
      if (win[i] && (perf_q[i] != {CNT_W{1'b1}})) begin
        perf_d[i] = perf_q[i] + CNT_W'(1);
      end else begin
        perf_d[i] = perf_q[i];
      end
    end
  end

  // Counter registers
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rst) begin
        perf_q[i] <= {CNT_W{1'b0}};
      end else begin
        perf_q[i] <= perf_d[i];
      end
    end
  end

  assign perf_lw_stall  = perf_q[0];
  assign perf_br_stall  = perf_q[1];
  assign perf_div_stall = perf_q[2];
  assign perf_mem_stall = perf_q[3];
`else
  // Build without performance counters: the hold flags only steer the stalls
`endif

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Directed self-checking bench for hazard_unit_mc (DIV_CYCLES = 4).
module tb_hazard_unit_mc;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rsD, rtD, rsE, rtE, write_regE, write_regM, write_regW;
  logic       use_rsD, use_rtD, reg_write_enE, reg_write_enM, reg_write_enW;
  logic       mem_to_regE, mem_to_regM, branchD, hilo_readE;
  logic       hilo_write_enM, hilo_write_enW, div_startE, mem_reqM, mem_okM, exc_flush;
  logic [1:0] forwardAE, forwardBE, forward_hilo;
  logic       forwardAD, forwardBD;
  logic       stallF, stallD, stallE, stallM, stallW;
  logic       flushD, flushE, flushM, flushW;
  logic       div_busy, div_done;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_lw_stall, perf_br_stall, perf_div_stall, perf_mem_stall;
`endif

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  hazard_unit_mc #(.REG_AW(5), .DIV_CYCLES(4)) u_dut (
    .clk(clk), .rst(rst),
    .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
    .use_rsD(use_rsD), .use_rtD(use_rtD),
    .write_regE(write_regE), .write_regM(write_regM), .write_regW(write_regW),
    .reg_write_enE(reg_write_enE), .reg_write_enM(reg_write_enM), .reg_write_enW(reg_write_enW),
    .mem_to_regE(mem_to_regE), .mem_to_regM(mem_to_regM), .branchD(branchD),
    .hilo_readE(hilo_readE), .hilo_write_enM(hilo_write_enM), .hilo_write_enW(hilo_write_enW),
    .div_startE(div_startE), .mem_reqM(mem_reqM), .mem_okM(mem_okM), .exc_flush(exc_flush),
    .forwardAE(forwardAE), .forwardBE(forwardBE), .forwardAD(forwardAD), .forwardBD(forwardBD),
    .forward_hilo(forward_hilo),
    .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM), .stallW(stallW),
    .flushD(flushD), .flushE(flushE), .flushM(flushM), .flushW(flushW),
    .div_busy(div_busy), .div_done(div_done)
`ifdef HAZARD_PERF_CNT_EN
    , .perf_lw_stall(perf_lw_stall), .perf_br_stall(perf_br_stall)
    , .perf_div_stall(perf_div_stall), .perf_mem_stall(perf_mem_stall)
`endif
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    rsD = 5'd0; rtD = 5'd0; rsE = 5'd0; rtE = 5'd0;
    write_regE = 5'd0; write_regM = 5'd0; write_regW = 5'd0;
    use_rsD = 1'b0; use_rtD = 1'b0;
    reg_write_enE = 1'b0; reg_write_enM = 1'b0; reg_write_enW = 1'b0;
    mem_to_regE = 1'b0; mem_to_regM = 1'b0; branchD = 1'b0;
    hilo_readE = 1'b0; hilo_write_enM = 1'b0; hilo_write_enW = 1'b0;
    div_startE = 1'b0; mem_reqM = 1'b0; mem_okM = 1'b0; exc_flush = 1'b0;
  endtask

  task automatic test_reset;
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    n_vec++;
    if ({stallF, stallD, stallE, stallM, stallW} !== 5'b00000) begin
      n_miss++; $display("FAIL reset_stalls got %b exp 00000", {stallF, stallD, stallE, stallM, stallW});
    end
    n_vec++;
    if ({flushD, flushE, flushM, flushW} !== 4'b0000) begin
      n_miss++; $display("FAIL reset_flushes got %b exp 0000", {flushD, flushE, flushM, flushW});
    end
    n_vec++;
    if ({div_busy, div_done} !== 2'b00) begin
      n_miss++; $display("FAIL reset_div got busy,done=%b exp 00", {div_busy, div_done});
    end
    n_vec++;
    if ({forwardAE, forwardBE, forward_hilo} !== 6'b000000) begin
      n_miss++; $display("FAIL reset_fwd got %b exp 000000", {forwardAE, forwardBE, forward_hilo});
    end
  endtask

  task automatic test_forward;
    clear_inputs();
    rsE = 5'd5; rtE = 5'd5; write_regM = 5'd5; reg_write_enM = 1'b1;
    write_regW = 5'd5; reg_write_enW = 1'b1;
    rsD = 5'd5; rtD = 5'd0;
    #1;
    n_vec++;
    if (forwardAE !== 2'b10) begin n_miss++; $display("FAIL fwdAE_m_wins got %b exp 10", forwardAE); end
    n_vec++;
    if (forwardBE !== 2'b10) begin n_miss++; $display("FAIL fwdBE_m_wins got %b exp 10", forwardBE); end
    n_vec++;
    if ({forwardAD, forwardBD} !== 2'b10) begin
      n_miss++; $display("FAIL fwdD got AD,BD=%b exp 10", {forwardAD, forwardBD});
    end
    reg_write_enM = 1'b0;
    #1;
    n_vec++;
    if (forwardAE !== 2'b01) begin n_miss++; $display("FAIL fwdAE_w got %b exp 01", forwardAE); end
    n_vec++;
    if (forwardAD !== 1'b0) begin n_miss++; $display("FAIL fwdAD_noen got %b exp 0", forwardAD); end
    reg_write_enM = 1'b1; rsE = 5'd0; write_regM = 5'd0; write_regW = 5'd0;
    #1;
    n_vec++;
    if (forwardAE !== 2'b00) begin n_miss++; $display("FAIL fwdAE_r0 got %b exp 00", forwardAE); end
    rtE = 5'd7; write_regW = 5'd7; write_regM = 5'd6;
    #1;
    n_vec++;
    if (forwardBE !== 2'b01) begin n_miss++; $display("FAIL fwdBE_w got %b exp 01", forwardBE); end
  endtask

  task automatic test_hilo;
    clear_inputs();
    hilo_readE = 1'b1; hilo_write_enM = 1'b1; hilo_write_enW = 1'b1;
    #1;
    n_vec++;
    if (forward_hilo !== 2'b10) begin n_miss++; $display("FAIL hilo_m got %b exp 10", forward_hilo); end
    hilo_write_enM = 1'b0;
    #1;
    n_vec++;
    if (forward_hilo !== 2'b01) begin n_miss++; $display("FAIL hilo_w got %b exp 01", forward_hilo); end
    hilo_readE = 1'b0; hilo_write_enM = 1'b1;
    #1;
    n_vec++;
    if (forward_hilo !== 2'b00) begin n_miss++; $display("FAIL hilo_noread got %b exp 00", forward_hilo); end
  endtask

  task automatic test_lwstall;
    clear_inputs();
    mem_to_regE = 1'b1; write_regE = 5'd8; rtD = 5'd8; use_rtD = 1'b1;
    #1;
    n_vec++;
    if ({stallF, stallD, stallE, stallM, stallW, flushE} !== 6'b110001) begin
      n_miss++; $display("FAIL lw_stall got F,D,E,M,W,flushE=%b exp 110001",
                         {stallF, stallD, stallE, stallM, stallW, flushE});
    end
    use_rtD = 1'b0;
    #1;
    n_vec++;
    if ({stallF, stallD, flushE} !== 3'b000) begin
      n_miss++; $display("FAIL lw_no_use got %b exp 000", {stallF, stallD, flushE});
    end
    use_rtD = 1'b1; write_regE = 5'd0; rtD = 5'd0;
    #1;
    n_vec++;
    if ({stallF, stallD, flushE} !== 3'b000) begin
      n_miss++; $display("FAIL lw_r0 got %b exp 000", {stallF, stallD, flushE});
    end
  endtask

  task automatic test_branchstall;
    clear_inputs();
    branchD = 1'b1; reg_write_enE = 1'b1; write_regE = 5'd9; rsD = 5'd9;
    #1;
    n_vec++;
    if ({stallF, stallD, stallE, flushE} !== 4'b1101) begin
      n_miss++; $display("FAIL br_alu_e got F,D,E,flushE=%b exp 1101", {stallF, stallD, stallE, flushE});
    end
    reg_write_enE = 1'b0; mem_to_regM = 1'b1; write_regM = 5'd9; rsD = 5'd3; rtD = 5'd9;
    #1;
    n_vec++;
    if ({stallF, stallD, stallE, flushE} !== 4'b1101) begin
      n_miss++; $display("FAIL br_load_m got %b exp 1101", {stallF, stallD, stallE, flushE});
    end
    branchD = 1'b0;
    #1;
    n_vec++;
    if ({stallF, stallD, flushE} !== 3'b000) begin
      n_miss++; $display("FAIL br_nobranch got %b exp 000", {stallF, stallD, flushE});
    end
  endtask

  task automatic test_memstall;
    clear_inputs();
    mem_reqM = 1'b1; mem_okM = 1'b1;
    #1;
    n_vec++;
    if ({stallF, stallD, stallE, stallM, stallW} !== 5'b00000) begin
      n_miss++; $display("FAIL mem_ok_same got %b exp 00000", {stallF, stallD, stallE, stallM, stallW});
    end
    mem_okM = 1'b0;
    #1;
    n_vec++;
    if ({stallF, stallD, stallE, stallM, stallW, flushE} !== 6'b111110) begin
      n_miss++; $display("FAIL mem_wait got %b exp 111110", {stallF, stallD, stallE, stallM, stallW, flushE});
    end
  endtask

  task automatic test_div;
    clear_inputs();
    div_startE = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_vec++;
      if ({stallF, stallD, stallE, stallM, stallW, flushE, div_busy, div_done} !==
          {5'b11111, 1'b0, (c != 0), 1'b0}) begin
        n_miss++; $display("FAIL div_stall c=%0d got stalls,flushE,busy,done=%b exp %b", c,
                           {stallF, stallD, stallE, stallM, stallW, flushE, div_busy, div_done},
                           {5'b11111, 1'b0, (c != 0), 1'b0});
      end
      tick();
    end
    #1;
    n_vec++;
    if ({stallF, stallD, stallE, stallM, stallW, div_busy, div_done} !== 7'b0000011) begin
      n_miss++; $display("FAIL div_done_cycle got %b exp 0000011",
                         {stallF, stallD, stallE, stallM, stallW, div_busy, div_done});
    end
    tick();
    div_startE = 1'b0;
    #1;
    n_vec++;
    if ({div_busy, div_done} !== 2'b00) begin
      n_miss++; $display("FAIL div_after_done got %b exp 00", {div_busy, div_done});
    end
  endtask

  task automatic test_div_memstall;
    clear_inputs();
    div_startE = 1'b1;
    for (int c = 0; c < 8; c++) begin
      // cycles 1..3: memory wait plus a pending load-use that must stay masked
      if (c >= 1 && c <= 3) begin
        mem_reqM = 1'b1; mem_okM = 1'b0;
        mem_to_regE = 1'b1; write_regE = 5'd8; rtD = 5'd8; use_rtD = 1'b1;
      end else begin
        mem_reqM = 1'b0; mem_to_regE = 1'b0; use_rtD = 1'b0;
      end
      #1;
      n_vec++;
      if ({stallF, stallD, stallE, stallM, stallW, flushE, div_done} !== 7'b1111100) begin
        n_miss++; $display("FAIL divmem_stall c=%0d got %b exp 1111100", c,
                           {stallF, stallD, stallE, stallM, stallW, flushE, div_done});
      end
      tick();
    end
    #1;
    n_vec++;
    if ({stallF, stallD, stallE, stallM, stallW, div_done} !== 6'b000001) begin
      n_miss++; $display("FAIL divmem_done got %b exp 000001",
                         {stallF, stallD, stallE, stallM, stallW, div_done});
    end
    tick();
    div_startE = 1'b0;
  endtask

  task automatic test_exc_flush;
    clear_inputs();
    div_startE = 1'b1;
    tick();
    tick();
    exc_flush = 1'b1;
    #1;
    n_vec++;
    if ({flushD, flushE, flushM, flushW, stallF, stallD, stallE, stallM, stallW, div_done} !==
        10'b1111000000) begin
      n_miss++; $display("FAIL exc_flush got flushes,stalls,done=%b exp 1111000000",
                         {flushD, flushE, flushM, flushW, stallF, stallD, stallE, stallM, stallW, div_done});
    end
    tick();
    exc_flush = 1'b0;
    div_startE = 1'b0;
    #1;
    n_vec++;
    if ({div_busy, stallF, stallE} !== 3'b000) begin
      n_miss++; $display("FAIL exc_idle got busy,stallF,stallE=%b exp 000", {div_busy, stallF, stallE});
    end
    for (int c = 0; c < 6; c++) begin
      tick();
      n_vec++;
      if (div_done !== 1'b0) begin
        n_miss++; $display("FAIL exc_no_done c=%0d got %b exp 0", c, div_done);
      end
    end
  endtask

  task automatic test_reset_mid_busy;
    clear_inputs();
    div_startE = 1'b1;
    tick();
    tick();
    n_vec++;
    if (div_busy !== 1'b1) begin n_miss++; $display("FAIL rstmid_pre got busy=%b exp 1", div_busy); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    div_startE = 1'b0;
    #1;
    n_vec++;
    if ({div_busy, div_done, stallF, stallW} !== 4'b0000) begin
      n_miss++; $display("FAIL rstmid_post got busy,done,stallF,stallW=%b exp 0000",
                         {div_busy, div_done, stallF, stallW});
    end
`ifdef HAZARD_PERF_CNT_EN
    n_vec++;
    if ({perf_lw_stall, perf_br_stall, perf_div_stall, perf_mem_stall} !== 128'd0) begin
      n_miss++; $display("FAIL perf_clear got lw=%0d br=%0d div=%0d mem=%0d exp 0",
                         perf_lw_stall, perf_br_stall, perf_div_stall, perf_mem_stall);
    end
`endif
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_forward();
    test_hilo();
    test_lwstall();
    test_branchstall();
    test_memstall();
    test_div();
    test_div_memstall();
    test_exc_flush();
    test_reset_mid_busy();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/hazard_unit_mc.md
Name: hazard_unit_mc

Overview:
- Next-generation hazard/forwarding unit for the 5-stage MIPS pipeline (F/D/E/M/W).
- Adds to plain forwarding and load-use/branch stalls:
  - an internal multi-cycle divider sequencer that generates its own stall;
  - a variable-latency data-memory wait stall;
  - an exception flush that aborts in-flight long operations.
- Register-address width and divider latency are parametrised. Sits beside the datapath and drives all stall, flush and forward selects.

Parameters:
- REG_AW, 5, register-address width; the register file has 2**REG_AW entries, and register 0 is hard-wired zero.
- DIV_CYCLES, 32, busy cycles of the divider; legal range 2..255.
- CNT_W, 32, width of performance counters (optional feature only).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rsD, rtD, rsE, rtE  in  REG_AW each  source registers in D and E
- use_rsD, use_rtD  in  1 each  D instruction actually reads rs/rt
- write_regE, write_regM, write_regW  in  REG_AW each  destinations
- reg_write_enE, reg_write_enM, reg_write_enW  in  1 each
- mem_to_regE, mem_to_regM  in  1 each  load in E/M
- branchD  in  1  branch/jr resolved in D
- hilo_readE  in  1  E reads HI/LO
- hilo_write_enM, hilo_write_enW  in  1 each
- div_startE  in  1  divide instruction in E
- mem_reqM  in  1  M issues data access
- mem_okM  in  1  data access completes this cycle
- exc_flush  in  1  exception/eret: flush the whole pipeline
- forwardAE, forwardBE  out  2 each  00 = regfile, 10 = M, 01 = W
- forwardAD, forwardBD  out  1 each  forward from M to D
- forward_hilo  out  2  00 = none, 10 = M, 01 = W
- stallF, stallD, stallE, stallM, stallW  out  1 each
- flushD, flushE, flushM, flushW  out  1 each
- div_busy  out  1  divider FSM not IDLE
- div_done  out  1  one-cycle pulse: quotient/remainder valid

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - FSM returns to IDLE and the counter clears.
  - All registered outputs go to 0.
  - Combinational outputs follow their equations; stalls fall to 0 once the FSM is IDLE.
- Forwarding (combinational):
  - forwardAE = 10 if rsE != 0, rsE == write_regM and reg_write_enM; else 01 on the same test against W; else 00. forwardBE is identical using rtE.
  - forwardAD/BD: rsD/rtD != 0, equal to write_regM, and reg_write_enM.
  - forward_hilo = 10 if hilo_readE & hilo_write_enM; else 01 if hilo_readE & hilo_write_enW; else 00. It is never latched.
- lwstall = mem_to_regE & write_regE != 0 & ((use_rsD & rsD == write_regE) | (use_rtD & rtD == write_regE)).
- branchstall = branchD & ((reg_write_enE & write_regE != 0 & write_regE ∈ {rsD, rtD}) | (mem_to_regM & write_regM != 0 & write_regM ∈ {rsD, rtD})).
- memstall = mem_reqM & ~mem_okM.
- Divider FSM, states IDLE, BUSY, DONE:
  - IDLE -> BUSY on div_startE & ~exc_flush; cnt loads DIV_CYCLES-1.
  - BUSY: cnt decrements each cycle that memstall is 0. At cnt == 0 -> DONE.
  - DONE: div_done = 1 for one cycle, then -> IDLE.
  - exc_flush in any state -> IDLE at the next edge; div_done is suppressed.
  - divstall = (IDLE & div_startE) | BUSY. No stall in DONE, so E advances that cycle.
- Priority, first matching case wins:
  1. exc_flush: all flushD..W = 1, all stalls = 0.
  2. memstall | divstall: stallF..W all = 1, no flushes; lw/branch stalls are masked.
  3. lwstall | branchstall: stallF = stallD = 1, flushE = 1; M and W advance.
  4. Otherwise all 0.
- Simultaneous memstall and div BUSY: the divider counter freezes; both stalls hold until both clear.
- mem_okM in the same cycle as mem_reqM: no stall.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- When defined, add outputs perf_lw_stall, perf_br_stall, perf_div_stall, perf_mem_stall, each CNT_W wide.
  - Each counts cycles in which its stall class is the winning cause under the priority order above.
  - Counters saturate at all-ones and clear on rst.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Decomposition:
- Shared package hazard_pkg holds:
  - forward-select constants FWD_RF = 2'b00, FWD_W = 2'b01, FWD_M = 2'b10;
  - the divider state enum (IDLE, BUSY, DONE).
- One natural sub-module: div_seq, holding the divider FSM and counter, with outputs div_busy, div_done and divstall.

Test Plan:
- rsE = 5, write_regM = 5 with reg_write_enM, and write_regW = 5 with reg_write_enW -> forwardAE = 10 (M wins). Repeat with rsE = 0 -> forwardAE = 00.
- Load to r8 in E, D reads rt = 8 with use_rtD = 1 -> stallF = stallD = flushE = 1 for one cycle. Repeat with use_rtD = 0 -> no stall.
- div_startE with DIV_CYCLES = 4 -> stallF..W = 1 for 5 cycles (the start cycle plus 4 BUSY cycles); div_done pulses on the following cycle, when all stalls are 0.
- Divider BUSY with mem_reqM = 1, mem_okM = 0 for 3 cycles -> cnt frozen, total stall extended by 3; no flushE asserted.
- exc_flush in the second BUSY cycle -> flushD..W = 1, stalls = 0 that cycle; FSM IDLE next cycle; div_done never asserted.
- rst asserted mid-BUSY -> FSM IDLE and div_busy = 0 after that edge. With HAZARD_PERF_CNT_EN defined, all perf counters read 0.
